// File: rtl/usr_pkg.sv
// Shared types for the universal shift register transfer block.
// State enum and datapath mode encodings.
package usr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } usr_state_e;

  // 2'b01 is reserved; the controller never drives it.
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/usr_datapath.sv
// Universal shift register: hold, shift right (serial_in at MSB), load.
// Ports: clk, reset (sync, high), mode, serial_in, par_in -> q.
module usr_datapath
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    case (mode)
      MODE_SHR:  q_d = {serial_in, q_q[WIDTH-1:1]};
      MODE_LOAD: q_d = par_in;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/usr_xfer_ctrl.sv
// Word-to-serial transfer sequencer around usr_datapath.
// Ports: start handshake + tx_data in, sdi/sdo/bit_tick, rx handshake + rx_data out.
module usr_xfer_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             sdi,
  output logic             sdo,
  output logic             bit_tick,
  output logic             busy,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] rx_data
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  usr_state_e       state_q, state_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]       mode;
  logic [WIDTH-1:0] q;
  logic             tick;

  assign tick = (state_q == ST_SHIFT) && (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    mode      = MODE_HOLD;
    unique case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          mode      = MODE_LOAD;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          mode      = MODE_SHR;
          div_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) state_d = ST_DONE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (rx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  usr_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .serial_in (sdi),
    .par_in    (tx_data),
    .q         (q)
  );

  // Held low while reset is applied so no word is taken in that cycle.
  assign start_ready = (state_q == ST_IDLE) && !reset;
  assign sdo         = (state_q == ST_SHIFT) && q[0];
  assign bit_tick    = tick;
  assign busy        = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign rx_valid    = (state_q == ST_DONE);
  assign rx_data     = q;

endmodule

// File: tb/tb_usr_xfer_ctrl.sv
// Bench for usr_xfer_ctrl: three instances (4/1, 4/2, 8/3) against a
// per-cycle reference derived from word, serial input and period.
module tb_usr_xfer_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] sv = '0, rr = '0, sdi_r = '0;
  logic [2:0] sr, sdo, tick, busy, rxv, sdi_in;
  logic [3:0] txd0 = '0, txd1 = '0, rxd0, rxd1;
  logic [7:0] txd2 = '0, rxd2;
  logic       loop = 1'b0;

  int W[3]  = '{4, 4, 8};
  int DV[3] = '{1, 2, 3};
  int nchk = 0, nerr = 0;
  int cyc = 0;
  int last_acc[3] = '{0, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  assign sdi_in[0] = loop ? sdo[0] : sdi_r[0];
  assign sdi_in[1] = sdi_r[1];
  assign sdi_in[2] = sdi_r[2];

  usr_xfer_ctrl #(.WIDTH(4), .DIV(1)) u0 (
    .clk(clk), .reset(reset), .start_valid(sv[0]), .start_ready(sr[0]),
    .tx_data(txd0), .sdi(sdi_in[0]), .sdo(sdo[0]), .bit_tick(tick[0]),
    .busy(busy[0]), .rx_valid(rxv[0]), .rx_ready(rr[0]), .rx_data(rxd0));

  usr_xfer_ctrl #(.WIDTH(4), .DIV(2)) u1 (
    .clk(clk), .reset(reset), .start_valid(sv[1]), .start_ready(sr[1]),
    .tx_data(txd1), .sdi(sdi_in[1]), .sdo(sdo[1]), .bit_tick(tick[1]),
    .busy(busy[1]), .rx_valid(rxv[1]), .rx_ready(rr[1]), .rx_data(rxd1));

  usr_xfer_ctrl #(.WIDTH(8), .DIV(3)) u2 (
    .clk(clk), .reset(reset), .start_valid(sv[2]), .start_ready(sr[2]),
    .tx_data(txd2), .sdi(sdi_in[2]), .sdo(sdo[2]), .bit_tick(tick[2]),
    .busy(busy[2]), .rx_valid(rxv[2]), .rx_ready(rr[2]), .rx_data(rxd2));

  function automatic logic [7:0] rxd_of(int d);
    case (d)
      0:       return {4'b0, rxd0};
      1:       return {4'b0, rxd1};
      default: return rxd2;
    endcase
  endfunction

  task automatic set_tx(int d, logic [7:0] v);
    case (d)
      0:       txd0 = v[3:0];
      1:       txd1 = v[3:0];
      default: txd2 = v;
    endcase
  endtask

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete word on instance d. sw is the serial input word
  // (bit k presented during bit period k); hold = cycles rx_ready stays low.
  task automatic xfer(int d, logic [7:0] tx, logic [7:0] sw,
                      int hold, int gap);
    int w, dv, n, k;
    logic [7:0] msk;
    w = W[d];
    dv = DV[d];
    msk = (w == 8) ? 8'hFF : 8'h0F;
    tx = tx & msk;
    sw = sw & msk;
    n = 0;
    while (!sr[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("start_ready_wait", {7'b0, sr[d]}, 8'h01);
    if (gap != 0) chk("accept_gap", 8'(cyc - last_acc[d]), 8'(gap));
    last_acc[d] = cyc;
    set_tx(d, tx);
    sv[d] = 1'b1;
    @(posedge clk); #1;
    sv[d] = 1'b0;
    for (int c = 1; c <= w * dv; c++) begin
      k = (c - 1) / dv;
      sdi_r[d] = sw[k];
      @(negedge clk);
      chk("sdo", {7'b0, sdo[d]}, {7'b0, tx[k]});
      chk("bit_tick", {7'b0, tick[d]}, {7'b0, (c % dv) == 0});
      chk("busy_shift", {7'b0, busy[d]}, 8'h01);
      chk("rxv_shift", {7'b0, rxv[d]}, 8'h00);
      chk("sr_shift", {7'b0, sr[d]}, 8'h00);
      @(posedge clk); #1;
    end
    for (int h = 0; h < hold; h++) begin
      rr[d] = 1'b0;
      sv[d] = 1'b1;
      set_tx(d, ~tx);
      @(negedge clk);
      chk("rxv_hold", {7'b0, rxv[d]}, 8'h01);
      chk("rxd_hold", rxd_of(d), sw);
      chk("sr_hold", {7'b0, sr[d]}, 8'h00);
      chk("sdo_hold", {7'b0, sdo[d]}, 8'h00);
      @(posedge clk); #1;
    end
    sv[d] = 1'b0;
    set_tx(d, tx);
    rr[d] = 1'b1;
    @(negedge clk);
    chk("rxv_done", {7'b0, rxv[d]}, 8'h01);
    chk("rxd_done", rxd_of(d), sw);
    chk("busy_done", {7'b0, busy[d]}, 8'h01);
    @(posedge clk); #1;
    rr[d] = 1'b0;
    @(negedge clk);
    chk("sr_idle", {7'b0, sr[d]}, 8'h01);
    chk("busy_idle", {7'b0, busy[d]}, 8'h00);
    chk("rxv_idle", {7'b0, rxv[d]}, 8'h00);
  endtask

  initial begin
    logic [7:0] tx, sw;
    int d;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_sr", {7'b0, sr[i]}, 8'h00);
      chk("rst_busy", {7'b0, busy[i]}, 8'h00);
      chk("rst_rxv", {7'b0, rxv[i]}, 8'h00);
      chk("rst_tick", {7'b0, tick[i]}, 8'h00);
      chk("rst_sdo", {7'b0, sdo[i]}, 8'h00);
      chk("rst_rxd", rxd_of(i), 8'h00);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("rst_sr_after", {5'b0, sr}, 8'h07);
    @(posedge clk); #1;

    // Loopback, 4/1, word 1011.
    loop = 1'b1;
    xfer(0, 8'h0B, 8'h0B, 0, 0);
    loop = 1'b0;

    // 4/2, all-zero word with sdi held high.
    xfer(1, 8'h00, 8'h0F, 0, 0);

    // Consumer stall while a new word is offered.
    xfer(0, 8'h06, 8'h09, 5, 0);

    // Back-to-back words at the minimum period.
    xfer(0, 8'h0C, 8'h03, 0, 0);
    xfer(0, 8'h05, 8'h0A, 0, 6);
    xfer(0, 8'h0E, 8'h01, 0, 6);

    // 8/3, A5 out while 3C comes in.
    xfer(2, 8'hA5, 8'h3C, 0, 0);

    // Reset in cycle 2 of a transfer discards the word.
    @(posedge clk); #1;
    set_tx(0, 8'h0F);
    sdi_r[0] = 1'b1;
    sv[0] = 1'b1;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_sr", {7'b0, sr[0]}, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", {7'b0, busy[0]}, 8'h00);
    chk("mid_rst_sdo", {7'b0, sdo[0]}, 8'h00);
    chk("mid_rst_q", rxd_of(0), 8'h00);
    chk("mid_rst_sr1", {7'b0, sr[0]}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mid_rst_no_rxv", {7'b0, rxv[0]}, 8'h00);
    end
    sdi_r = '0;
    @(posedge clk); #1;

    // Randomized words on random instances.
    for (int i = 0; i < 8; i++) begin
      d = int'($urandom_range(0, 2));
      tx = 8'($urandom);
      sw = 8'($urandom);
      xfer(d, tx, sw, int'($urandom_range(0, 3)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
